// File: rtl/core2apb_pkg.sv
// Shared types and constants for the core-to-APB bridge.
//   apb_mst_state_e : initiator FSM states
//   FULL_BE         : byte-enable pattern of a full-word access
package core2apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_e;

  localparam logic [3:0] FULL_BE = 4'hF;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Bus-hang watchdog for the APB ACCESS phase.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (has priority over en_i)
//   en_i          : count this cycle (an ACCESS cycle without PREADY)
//   expired_o     : combinational pulse in the cycle the count reaches Limit
// A Limit of 0 disables the watchdog; expired_o then stays low.
module apb_timeout_cnt #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // The count only ever holds 0..Limit-1; reaching Limit is signalled, not stored.
  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;
  localparam bit Enabled = (Limit != 0);
  localparam logic [CntW-1:0] LastCnt = Enabled ? CntW'(Limit - 1) : '0;

  logic [CntW-1:0] cnt_q;

  always_comb begin
    expired_o = Enabled && en_i && (cnt_q == LastCnt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || expired_o) begin
      cnt_q <= '0;
    end else if (en_i && Enabled) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/core2apb_bridge.sv
// APB3 initiator: turns core request/grant/rvalid data-port transactions into
// single APB transfers, one at a time.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   data_req_i / data_gnt_o : core request, grant (combinational, IDLE only)
//   data_addr_i, data_we_i, data_be_i, data_wdata_i : request payload
//   data_rvalid_o, data_rdata_o, data_err_o         : one-cycle response
//   apb_paddr_o, apb_pwdata_o, apb_pwrite_o, apb_psel_o, apb_penable_o : APB drive
//   apb_prdata_i, apb_pready_i, apb_pslverr_i                          : APB sample
// Sub-word writes are rejected with an error and never reach the bus.
module core2apb_bridge
  import core2apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
  output logic                      data_err_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i
);

  apb_mst_state_e            state_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      rvalid_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;

  logic tmo_clr;
  logic tmo_en;
  logic tmo_expired;

  // Counter runs only while waiting for PREADY; any other state wipes it.
  always_comb begin
    tmo_clr = (state_q != ACCESS);
    tmo_en  = (state_q == ACCESS) && !apb_pready_i;
  end

  apb_timeout_cnt #(
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  always_comb begin
    data_gnt_o = (state_q == IDLE) && data_req_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (data_req_i) begin
            paddr_q  <= data_addr_i;
            pwrite_q <= data_we_i;
            pwdata_q <= data_wdata_i;
            if (data_we_i && (data_be_i != FULL_BE)) begin
              // Sub-word write: answer with an error, no bus cycle.
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              rdata_q  <= '0;
              err_q    <= 1'b1;
            end else begin
              state_q <= SETUP;
              psel_q  <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // PREADY wins over a timeout expiring in the same cycle.
          if (apb_pready_i) begin
            state_q   <= RESP;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= pwrite_q ? '0 : apb_prdata_i;
            err_q     <= apb_pslverr_i;
          end else if (tmo_expired) begin
            state_q   <= RESP;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= '0;
            err_q     <= 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    data_rvalid_o = rvalid_q;
    data_rdata_o  = rdata_q;
    data_err_o    = err_q;
    apb_paddr_o   = paddr_q;
    apb_pwdata_o  = pwdata_q;
    apb_pwrite_o  = pwrite_q;
    apb_psel_o    = psel_q;
    apb_penable_o = penable_q;
  end

endmodule

// File: tb/tb_core2apb_bridge.sv
// Self-checking bench for core2apb_bridge: directed vector table, hand-written
// back-to-back and reset sequences, then random transfers against a
// transfer-level reference model. The bench plays the APB completer.
module tb_core2apb_bridge;

  localparam int unsigned Tmo = 8;

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;     // PREADY asserted in ACCESS cycle waits+1
    int          lat;       // cycles from grant to rvalid
    logic [31:0] rdata;
    logic        err;
    int          psel_cyc;  // cycles psel is high
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  core2apb_bridge #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_req_i    (req),
    .data_gnt_o    (gnt),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .data_err_o    (err),
    .apb_paddr_o   (paddr),
    .apb_pwdata_o  (pwdata),
    .apb_pwrite_o  (pwrite),
    .apb_psel_o    (psel),
    .apb_penable_o (penable),
    .apb_prdata_i  (prdata),
    .apb_pready_i  (pready),
    .apb_pslverr_i (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input string name, input logic w, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] prd, input logic se, input int ws,
                              input int lat, input logic [31:0] rd, input logic e,
                              input int pc);
    vec_t v;
    v.name = name; v.we = w; v.be = b; v.addr = a; v.wdata = wd; v.prdata = prd;
    v.slverr = se; v.waits = ws; v.lat = lat; v.rdata = rd; v.err = e; v.psel_cyc = pc;
    return v;
  endfunction

  // Transfer-level model: outcome follows from the request kind and how long
  // the completer stalls, compared against the timeout budget.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.we && v.be != 4'hF) begin
      r.lat = 1; r.rdata = 0; r.err = 1'b1; r.psel_cyc = 0;
    end else if (v.waits < int'(Tmo)) begin
      r.lat = 3 + v.waits;
      r.rdata = v.we ? 32'h0 : v.prdata;
      r.err = v.slverr;
      r.psel_cyc = 2 + v.waits;
    end else begin
      r.lat = 2 + int'(Tmo); r.rdata = 0; r.err = 1'b1; r.psel_cyc = 1 + int'(Tmo);
    end
    return r;
  endfunction

  // Enter 1 time unit after a rising edge with the DUT idle.
  task automatic run_txn(input vec_t v);
    int acc = 0;
    int rv_cyc = -1;
    int pcyc = 0;
    bit stable = 1'b1;
    logic [31:0] got_rd = '0;
    logic got_err = 1'b0;
    req = 1'b1; addr = v.addr; we = v.we; be = v.be; wdata = v.wdata;
    pready = 1'b0;
    for (int c = 0; c < 24 && rv_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 0) chk({v.name, ".gnt"}, {31'b0, gnt}, 32'd1);
      if (psel) begin
        pcyc++;
        if (paddr !== v.addr || pwrite !== v.we || (v.we && pwdata !== v.wdata)) stable = 1'b0;
      end
      if (psel && penable) begin
        acc++;
        if (acc == v.waits + 1) begin
          pready = 1'b1; prdata = v.prdata; pslverr = v.slverr;
        end
      end
      if (rvalid) begin
        rv_cyc = c; got_rd = rdata; got_err = err;
      end
      @(posedge clk); #1;
      req = 1'b0; pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      addr = $urandom; wdata = $urandom;
    end
    if (rv_cyc < 0) begin
      chk({v.name, ".rvalid_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({v.name, ".lat"}, rv_cyc, v.lat);
      chk({v.name, ".rdata"}, got_rd, v.rdata);
      chk({v.name, ".err"}, {31'b0, got_err}, {31'b0, v.err});
      chk({v.name, ".psel_cycles"}, pcyc, v.psel_cyc);
      chk({v.name, ".apb_stable"}, {31'b0, stable}, 32'd1);
      @(negedge clk);
      chk({v.name, ".rvalid_pulse"}, {31'b0, rvalid}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    tbl.push_back(mk("zw_read",   0, 4'h0, 32'h1A10_0004, 32'h0, 32'hDEAD_BEEF, 0, 0,
                     3, 32'hDEAD_BEEF, 0, 2));
    tbl.push_back(mk("write_3ws", 1, 4'hF, 32'h1A10_0008, 32'h1234_5678, 32'h0BAD_0BAD, 0, 3,
                     6, 32'h0, 0, 5));
    tbl.push_back(mk("slverr_rd", 0, 4'hF, 32'h1A10_000C, 32'h0, 32'hCAFE_F00D, 1, 1,
                     4, 32'hCAFE_F00D, 1, 3));
    tbl.push_back(mk("timeout_rd", 0, 4'hF, 32'h1A10_0010, 32'h0, 32'h1111_2222, 0, 30,
                     10, 32'h0, 1, 9));
    tbl.push_back(mk("after_tmo", 0, 4'hF, 32'h1A10_0014, 32'h0, 32'h0102_0304, 0, 0,
                     3, 32'h0102_0304, 0, 2));
    tbl.push_back(mk("ready_8th", 0, 4'hF, 32'h1A10_0018, 32'h0, 32'h55AA_55AA, 0, 7,
                     10, 32'h55AA_55AA, 0, 9));
    tbl.push_back(mk("part_wr",   1, 4'h3, 32'h1A10_001C, 32'hFFFF_0000, 32'h0, 0, 0,
                     1, 32'h0, 1, 0));
    tbl.push_back(mk("wr_slverr", 1, 4'hF, 32'h1A10_0020, 32'hA0A0_B0B0, 32'h0, 1, 0,
                     3, 32'h0, 1, 2));
    tbl.push_back(mk("tmo_wr",    1, 4'hF, 32'h1A10_0024, 32'h7777_8888, 32'h0, 0, 8,
                     10, 32'h0, 1, 9));

    // Reset values
    #12;
    chk("rst.gnt", {31'b0, gnt}, 0);
    chk("rst.rvalid", {31'b0, rvalid}, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.err", {31'b0, err}, 0);
    chk("rst.psel", {31'b0, psel}, 0);
    chk("rst.penable", {31'b0, penable}, 0);
    chk("rst.pwrite", {31'b0, pwrite}, 0);
    chk("rst.paddr", paddr, 0);
    chk("rst.pwdata", pwdata, 0);
    @(negedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Back-to-back: request held high, completer always ready -> one per 4 cycles.
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h1A10_0100;
    pready = 1'b1; prdata = 32'hA5A5_0001; pslverr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("b2b.gnt%0d", c), {31'b0, gnt}, {31'b0, (c % 4) == 0});
      chk($sformatf("b2b.rvalid%0d", c), {31'b0, rvalid}, {31'b0, (c % 4) == 3});
      if (c % 4 == 3) chk($sformatf("b2b.rdata%0d", c), rdata, 32'hA5A5_0001);
      @(posedge clk); #1;
    end
    req = 1'b0; pready = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of ACCESS.
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h1A10_0200;
    @(negedge clk);
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid.in_access", {30'b0, psel, penable}, 32'd3);
    #2; rst_n = 1'b0;
    #1;
    chk("rstmid.psel", {31'b0, psel}, 0);
    chk("rstmid.penable", {31'b0, penable}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid.rvalid%0d", c), {31'b0, rvalid}, 0);
    end
    #2; rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.rvalid_after", {31'b0, rvalid}, 0);
    @(posedge clk); #1;
    run_txn(tbl[0]);

    // Random transfers checked against the model.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.name   = $sformatf("rnd%0d", i);
      v.we     = 1'($urandom);
      v.be     = 4'($urandom);
      if (v.we && $urandom_range(0, 3) != 0) v.be = 4'hF;
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.prdata = $urandom;
      v.slverr = ($urandom_range(0, 4) == 0);
      v.waits  = $urandom_range(0, 11);
      run_txn(model(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
